calc_responder: RTL and testbench

CALC_RESPONDER -- requirements
Module: calc_responder

---
 rtl/calc_responder_pkg.sv | 35 +++
 rtl/calc_req_fifo.sv | 54 +++++
 rtl/calc_responder.sv | 148 ++++++++++++++
 tb/tb_calc_responder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/calc_responder_pkg.sv
// Shared widths, command/response codes and request/result types for calc_responder.
package calc_responder_pkg;

  localparam int CMD_WIDTH  = 4;
  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH  = 2;
  localparam int RESP_WIDTH = 2;

  localparam logic [CMD_WIDTH-1:0] CMD_NONE = 4'd0;
  localparam logic [CMD_WIDTH-1:0] CMD_ADD  = 4'd1;
  localparam logic [CMD_WIDTH-1:0] CMD_SUB  = 4'd2;
  localparam logic [CMD_WIDTH-1:0] CMD_SHL  = 4'd5;
  localparam logic [CMD_WIDTH-1:0] CMD_SHR  = 4'd6;

  localparam logic [RESP_WIDTH-1:0] RESP_NONE = 2'd0;
  localparam logic [RESP_WIDTH-1:0] RESP_OK   = 2'd1;
  localparam logic [RESP_WIDTH-1:0] RESP_ERR  = 2'd2;

  // One queued request: command, tag and both operands.
  typedef struct packed {
    logic [CMD_WIDTH-1:0]  cmd;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
  } req_t;

  // Outcome of executing one request.
  typedef struct packed {
    logic [RESP_WIDTH-1:0] resp;
    logic [DATA_WIDTH-1:0] data;
  } result_t;

  localparam int REQ_WIDTH = $bits(req_t);

endpackage

// File: rtl/calc_req_fifo.sv
// Request FIFO: push/pop in the same cycle both take effect; pushes while full are dropped.
module calc_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/calc_responder.sv
// Two-cycle request capture, FIFO queueing and a registered execute stage.
module calc_responder
  import calc_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CMD_WIDTH-1:0]  cmd_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic [RESP_WIDTH-1:0] out_resp,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  typedef enum logic {IDLE, WAIT_OP2} state_t;

  state_t                state_q, state_d;
  logic                  capture;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [CMD_WIDTH-1:0]  cmd_p0;
  logic [TAG_WIDTH-1:0]  tag_p0;
  logic [DATA_WIDTH-1:0] op1_p0;
  req_t                  wreq;
  req_t                  rreq;
  req_t                  req_p1;
  logic                  vld_p1;
  result_t               res_p1;

  // Arithmetic for one request; error responses always carry zero data.
  function automatic result_t execute(input req_t r);
    result_t               res;
    logic [DATA_WIDTH:0]   sum;
    sum      = {1'b0, r.op1} + {1'b0, r.op2};
    res.resp = RESP_ERR;
    res.data = '0;
    case (r.cmd)
      CMD_ADD: begin
        if (!sum[DATA_WIDTH]) begin
          res.resp = RESP_OK;
          res.data = sum[DATA_WIDTH-1:0];
        end
      end
      CMD_SUB: begin
        if (r.op2 <= r.op1) begin
          res.resp = RESP_OK;
          res.data = r.op1 - r.op2;
        end
      end
      CMD_SHL: begin
        res.resp = RESP_OK;
        res.data = r.op1 << r.op2[4:0];
      end
      CMD_SHR: begin
        res.resp = RESP_OK;
        res.data = r.op1 >> r.op2[4:0];
      end
      default: begin
        res.resp = RESP_ERR;
        res.data = '0;
      end
    endcase
    return res;
  endfunction

  // Input FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: a command cycle is always followed by exactly one operand2 cycle.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_in != CMD_NONE) begin
          capture = 1'b1;
          state_d = WAIT_OP2;
        end
      end
      WAIT_OP2: begin
        push    = !full;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: hold command, tag and operand1 until operand2 arrives.
  always_ff @(posedge clk) begin
    if (capture) begin
      cmd_p0 <= cmd_in;
      tag_p0 <= tag_in;
      op1_p0 <= data_in;
    end
  end

  assign wreq = '{cmd: cmd_p0, tag: tag_p0, op1: op1_p0, op2: data_in};
  assign pop  = !empty;

  calc_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wreq),
    .rdata (rreq),
    .full  (full),
    .empty (empty)
  );

  // Stage p1: the popped request, registered on the pop edge.
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= pop;
  end

  // Stage p1 data path; validity is carried by vld_p1.
  always_ff @(posedge clk) begin
    if (pop) req_p1 <= rreq;
  end

  assign res_p1 = execute(req_p1);

  // Stage p2: response registers, zero whenever no request completes.
  always_ff @(posedge clk) begin
    if (reset || !vld_p1) begin
      out_resp <= RESP_NONE;
      out_data <= '0;
      out_tag  <= '0;
    end else begin
      out_resp <= res_p1.resp;
      out_data <= (res_p1.resp == RESP_OK) ? res_p1.data : '0;
      out_tag  <= req_p1.tag;
    end
  end

endmodule

// File: tb/tb_calc_responder.sv
// Scoreboard bench for calc_responder: directed requests, queued expectations, negedge monitor.
module tb_calc_responder;
  import calc_responder_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [CMD_WIDTH-1:0]  cmd_in = '0;
  logic [DATA_WIDTH-1:0] data_in = '0;
  logic [TAG_WIDTH-1:0]  tag_in = '0;
  logic [RESP_WIDTH-1:0] out_resp;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TAG_WIDTH-1:0]  out_tag;

  typedef struct {
    logic [RESP_WIDTH-1:0] resp;
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
    int                    cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  calc_responder #(.DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_in   (cmd_in),
    .data_in  (data_in),
    .tag_in   (tag_in),
    .out_resp (out_resp),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: flag overdue expectations, then match any presented response.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL missing_resp cyc=%0d: no response, required resp=%0d data=%h tag=%0d at cyc=%0d",
               cyc, exp_q[0].resp, exp_q[0].data, exp_q[0].tag, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (out_resp != RESP_NONE) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp cyc=%0d: got resp=%0d data=%h tag=%0d, required none",
                 cyc, out_resp, out_data, out_tag);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_resp !== e.resp || out_data !== e.data || out_tag !== e.tag || cyc != e.cyc) begin
          bad++;
          $display("FAIL resp_match: got resp=%0d data=%h tag=%0d cyc=%0d, required resp=%0d data=%h tag=%0d cyc=%0d",
                   out_resp, out_data, out_tag, cyc, e.resp, e.data, e.tag, e.cyc);
        end
      end
    end
  end

  task automatic check_idle(input string name);
    total++;
    if (out_resp !== '0 || out_data !== '0 || out_tag !== '0) begin
      bad++;
      $display("FAIL %s: got resp=%0d data=%h tag=%0d, required all zero",
               name, out_resp, out_data, out_tag);
    end
  endtask

  // Called at a negedge; drives command cycle then operand2 cycle, leaves inputs idle at a negedge.
  task automatic issue(input logic [CMD_WIDTH-1:0] c, input logic [TAG_WIDTH-1:0] t,
                       input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b,
                       input logic [RESP_WIDTH-1:0] er, input logic [DATA_WIDTH-1:0] ed,
                       input bit expect_it, input logic [CMD_WIDTH-1:0] c2 = '0,
                       input logic [TAG_WIDTH-1:0] t2 = '0);
    exp_t e;
    cmd_in  = c;
    tag_in  = t;
    data_in = a;
    @(negedge clk);
    cmd_in  = c2;
    tag_in  = t2;
    data_in = b;
    if (expect_it) begin
      e.resp = er;
      e.data = ed;
      e.tag  = t;
      e.cyc  = cyc + 3;
      exp_q.push_back(e);
    end
    @(negedge clk);
    cmd_in  = '0;
    tag_in  = '0;
    data_in = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset_outputs");
    reset = 1'b0;

    // First command in the first cycle with reset low.
    issue(CMD_ADD, 2'd2, 32'h0000_0005, 32'h0000_0003, RESP_OK, 32'h8, 1'b1);
    idle(3);
    issue(CMD_ADD, 2'd1, 32'hFFFF_FFFF, 32'h0000_0001, RESP_ERR, 32'h0, 1'b1);
    issue(CMD_SUB, 2'd3, 32'h0000_0003, 32'h0000_0005, RESP_ERR, 32'h0, 1'b1);
    issue(CMD_SUB, 2'd0, 32'h0000_0009, 32'h0000_0004, RESP_OK, 32'h5, 1'b1);
    issue(CMD_SUB, 2'd2, 32'h0000_0005, 32'h0000_0005, RESP_OK, 32'h0, 1'b1);
    issue(CMD_ADD, 2'd3, 32'h7FFF_FFFF, 32'h8000_0000, RESP_OK, 32'hFFFF_FFFF, 1'b1);
    issue(CMD_SHL, 2'd1, 32'h0000_0001, 32'h0000_0024, RESP_OK, 32'h10, 1'b1);
    issue(CMD_SHR, 2'd2, 32'h8000_0000, 32'd31, RESP_OK, 32'h1, 1'b1);
    issue(4'd3, 2'd3, 32'h1234_5678, 32'h1, RESP_ERR, 32'h0, 1'b1);
    issue(4'd15, 2'd0, 32'h1, 32'h1, RESP_ERR, 32'h0, 1'b1);
    idle(4);

    // Back-to-back requests, tags 0..3 in order.
    issue(CMD_ADD, 2'd0, 32'd10, 32'd1, RESP_OK, 32'd11, 1'b1);
    issue(CMD_SUB, 2'd1, 32'd20, 32'd5, RESP_OK, 32'd15, 1'b1);
    issue(CMD_SHL, 2'd2, 32'd3, 32'd2, RESP_OK, 32'd12, 1'b1);
    issue(CMD_SHR, 2'd3, 32'h100, 32'd4, RESP_OK, 32'h10, 1'b1);
    idle(4);

    // Duplicate outstanding tags.
    issue(CMD_ADD, 2'd1, 32'd1, 32'd1, RESP_OK, 32'd2, 1'b1);
    issue(CMD_ADD, 2'd1, 32'd2, 32'd2, RESP_OK, 32'd4, 1'b1);
    idle(4);

    // Command on the operand2 cycle is ignored.
    issue(CMD_ADD, 2'd0, 32'd7, 32'd8, RESP_OK, 32'd15, 1'b1, CMD_SUB, 2'd3);
    idle(5);

    // Reset mid-flight: first request answers before reset, the rest are discarded.
    issue(CMD_ADD, 2'd1, 32'd100, 32'd1, RESP_OK, 32'd101, 1'b1);
    issue(CMD_ADD, 2'd2, 32'd200, 32'd2, RESP_OK, 32'd202, 1'b0);
    cmd_in  = CMD_SUB;
    tag_in  = 2'd3;
    data_in = 32'd50;
    @(negedge clk);
    reset   = 1'b1;
    cmd_in  = '0;
    tag_in  = '0;
    data_in = 32'd1;
    @(negedge clk);
    check_idle("reset_midflight_out");
    reset   = 1'b0;
    data_in = '0;
    issue(CMD_ADD, 2'd3, 32'd40, 32'd2, RESP_OK, 32'd42, 1'b1);
    idle(3);
    check_idle("after_last_resp");
    idle(4);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout: bench still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
